jt053260_romarb: RTL and testbench
==================================

JT053260_ROMARB -- requirements
Module: jt053260_romarb

Interface
REQ-001 SHALL have parameter AW, default 21, sample ROM address width.
REQ-002 SHALL have parameter TOUT, default 255, max WAIT cycles before forced completion; 0 = no timeout.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cen  input  1  clock enable; gates new grants only.
REQ-006 SHALL have port ch_req  input  4  per-channel fetch request, held until ch_ack.
REQ-007 SHALL have port ch_addr  input  4*AW  packed channel byte addresses, ch0 in LSBs.
REQ-008 SHALL have port ch_ack  output  4  one-hot, one-cycle completion pulse.
REQ-009 SHALL have port ch_data  output  8  fetched byte, valid while ch_ack is non-zero.
REQ-010 SHALL have port rom_cs  output  1  ROM request strobe.
REQ-011 SHALL have port rom_addr  output  AW  ROM address, stable while rom_cs=1.
REQ-012 SHALL have port rom_data  input  8  ROM read data.
REQ-013 SHALL have port rom_ok  input  1  ROM data valid.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port tout_err  output  1  sticky, set on any timeout.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT.
REQ-017 In IDLE with cen=1 and any eligible request, SHALL latch the winner index and address, set rom_cs=1 and enter ISSUE on that edge. With cen=0, SHALL stay in IDLE.
REQ-018 SHALL spend exactly one cycle in ISSUE, then enter WAIT. rom_ok seen in ISSUE SHALL be ignored as stale.
REQ-019 In WAIT with rom_ok=1, SHALL register rom_data into ch_data, pulse ch_ack[winner], drop rom_cs and return to IDLE, all on the same edge.
REQ-020 Minimum latency SHALL be 3 edges from grant to ch_ack high, with rom_ok high on the first WAIT cycle.
REQ-021 Arbitration SHALL be round-robin: search starts at the channel after the last winner; the pointer resets to ch0 first.
REQ-022 The channel acked in the previous cycle SHALL be ineligible for the IDLE cycle directly after ack, which tolerates a one-cycle req drop delay.
REQ-023 If the winner drops ch_req during ISSUE/WAIT, SHALL finish the ROM access and discard the data; no ch_ack is issued.
REQ-024 Changes to ch_addr after grant SHALL have no effect on rom_addr.
REQ-025 With TOUT>0, a WAIT cycle counter SHALL count to TOUT. When rom_ok has not arrived by then, SHALL complete as in REQ-019 with ch_data=8'h00 and set tout_err.
REQ-026 When rom_ok and the timeout occur in the same cycle, SHALL treat it as rom_ok; tout_err is not set.
REQ-027 At most one ROM access SHALL be outstanding; ch_ack SHALL never have more than one bit set.

Reset
REQ-028 On rst_n=0, SHALL asynchronously clear these outputs: rom_cs=0, rom_addr=0, ch_ack=0, ch_data=0, busy=0, tout_err=0.
REQ-029 On rst_n=0, SHALL asynchronously set state=IDLE, RR pointer=ch0 and timeout counter=0.
REQ-030 Reset asserted mid-access SHALL abandon the access; no ack is issued after release.

Configuration
REQ-031 With macro JT053260_ROMARB_FIXPRIO_EN defined, SHALL use fixed priority ch0>ch1>ch2>ch3 instead of round-robin, and REQ-022 still applies. Without it, REQ-021 applies.

Structure
REQ-032 Package jt053260_pkg SHALL hold NCH=4, the default AW and the state enum type.
REQ-033 The winner select SHALL be the sub-module jt053260_rrsel: inputs are the request mask and pointer; outputs are a one-hot grant and a valid flag. The fixed-priority variant SHALL be compiled inside it.

Verification
REQ-034 Stimulus: single req ch2, addr 21'h1ABCD, rom_data 8'h5A with rom_ok in the first WAIT cycle. Required: rom_addr=21'h1ABCD, ch_ack=4'b0100 and ch_data=8'h5A 3 edges after grant.
REQ-035 Stimulus: all four reqs held continuously. Required: grants in order ch0,ch1,ch2,ch3,ch0. With FIXPRIO_EN the order is ch0,ch1,ch0,ch1 (REQ-022 mask).
REQ-036 Stimulus: rom_ok stuck low with TOUT=8. Required: ack after 8 WAIT cycles, ch_data=8'h00, tout_err=1 until reset.
REQ-037 Stimulus: ch1 drops req during WAIT. Required: rom_cs drops on rom_ok, ch_ack stays 0, next grant proceeds normally.
REQ-038 Stimulus: cen held low with pending req. Required: no rom_cs. cen pulsed once: exactly one grant.
REQ-039 Stimulus: rst_n pulsed low during WAIT. Required: all outputs 0 immediately; after release, a fresh grant starts from ch0.

Source files
------------

// File: rtl/jt053260_pkg.sv
// Shared constants, FSM state type and helpers for the 053260 sample-ROM arbiter.
package jt053260_pkg;

  localparam int unsigned NCH    = 4;
  localparam int unsigned AW_DEF = 21;
  localparam int unsigned IW     = $clog2(NCH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // One-hot to binary index; an all-zero input maps to 0.
  function automatic logic [IW-1:0] oh2idx(input logic [NCH-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) oh2idx = IW'(i);
    end
  endfunction

endpackage

// File: rtl/jt053260_rrsel.sv
// Winner select: one-hot grant from the request mask. Round-robin from i_ptr by
// default; fixed priority ch0>ch1>ch2>ch3 with JT053260_ROMARB_FIXPRIO_EN.
module jt053260_rrsel
  import jt053260_pkg::*;
(
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt_c,
  output logic           o_vld_c
);

`ifdef JT053260_ROMARB_FIXPRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt_c = '0;
    o_vld_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!o_vld_c && i_req[i]) begin
        o_gnt_c[i] = 1'b1;
        o_vld_c    = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] w_idx;

  // Scan starts at the pointer and wraps around the channel ring.
  always_comb begin
    o_gnt_c = '0;
    o_vld_c = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = i_ptr + IW'(i);
      if (!o_vld_c && i_req[w_idx]) begin
        o_gnt_c[w_idx] = 1'b1;
        o_vld_c        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/jt053260_romarb.sv
// Four-channel sample-ROM fetch arbiter with one outstanding access and WAIT timeout.
// Define JT053260_ROMARB_FIXPRIO_EN for fixed priority instead of round-robin.
module jt053260_romarb
  import jt053260_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned TOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_addr,
  output logic [NCH-1:0]    ch_ack,
  output logic [7:0]        ch_data,
  output logic              rom_cs,
  output logic [AW-1:0]     rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic              busy,
  output logic              tout_err
);

  localparam int unsigned   CW    = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TOUT - 1);

  state_t         r_state, w_state_nxt;
  logic [IW-1:0]  r_win, w_win_nxt, r_ptr, w_ptr_nxt, w_sel_idx;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_drop, w_drop_nxt, r_cs, w_cs_nxt, r_busy, r_terr, w_terr_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt, w_sel_addr;
  logic [NCH-1:0] r_ack, w_ack_nxt, w_elig, w_sel_gnt;
  logic [7:0]     r_data, w_data_nxt;
  logic           w_sel_vld, w_tmo, w_keep;

  // The channel acked last cycle sits out one IDLE cycle while its request falls.
  assign w_elig = ch_req & ~r_ack;

  jt053260_rrsel u_sel (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_sel_gnt),
    .o_vld_c (w_sel_vld)
  );

  assign w_sel_idx = oh2idx(w_sel_gnt);

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel_gnt[i]) w_sel_addr = ch_addr[i*AW +: AW];
    end
  end

  assign w_tmo  = (TOUT != 0) && (r_cnt == TLAST);
  assign w_keep = !r_drop && ch_req[r_win];

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_drop_nxt  = r_drop;
    w_cs_nxt    = r_cs;
    w_addr_nxt  = r_addr;
    w_ack_nxt   = '0;
    w_data_nxt  = r_data;
    w_terr_nxt  = r_terr;
    case (r_state)
      ST_IDLE: begin
        if (cen && w_sel_vld) begin
          w_state_nxt = ST_ISSUE;
          w_win_nxt   = w_sel_idx;
          w_ptr_nxt   = w_sel_idx + IW'(1);
          w_cs_nxt    = 1'b1;
          w_addr_nxt  = w_sel_addr;
          w_drop_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        // rom_ok here belongs to an earlier access and is ignored.
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
        w_drop_nxt  = r_drop | ~ch_req[r_win];
      end
      ST_WAIT: begin
        if (rom_ok || w_tmo) begin
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          if (w_keep) begin
            w_ack_nxt[r_win] = 1'b1;
            w_data_nxt       = rom_ok ? rom_data : 8'h00;
          end
          if (!rom_ok) w_terr_nxt = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt + CW'(1);
          w_drop_nxt = r_drop | ~ch_req[r_win];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
      r_cs    <= 1'b0;
      r_addr  <= '0;
      r_ack   <= '0;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drop  <= w_drop_nxt;
      r_cs    <= w_cs_nxt;
      r_addr  <= w_addr_nxt;
      r_ack   <= w_ack_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_terr  <= w_terr_nxt;
    end
  end

  assign ch_ack   = r_ack;
  assign ch_data  = r_data;
  assign rom_cs   = r_cs;
  assign rom_addr = r_addr;
  assign busy     = r_busy;
  assign tout_err = r_terr;

endmodule

// File: tb/tb_jt053260_romarb.sv
// Self-checking bench for jt053260_romarb: directed table, corner sequences and
// random traffic against a transaction-age reference model.
module tb_jt053260_romarb;

  localparam int AW   = 21;
  localparam int TOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cen;
  logic [3:0]      ch_req;
  logic [4*AW-1:0] ch_addr;
  logic [3:0]      ch_ack;
  logic [7:0]      ch_data;
  logic            rom_cs;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic            rom_ok;
  logic            busy;
  logic            tout_err;

  int n_checks = 0;
  int n_err    = 0;

  jt053260_romarb #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_ack(ch_ack), .ch_data(ch_data), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .busy(busy), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  // Reference model: an access is described by its age in edges since the grant.
  bit            m_active, m_drop, m_terr;
  int            m_age, m_win, m_last, m_prev_ack;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic [3:0]    m_ack;
  bit            hold [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_drop = 0; m_terr = 0; m_age = 0; m_win = 0;
    m_last = 3; m_prev_ack = -1; m_addr = '0; m_data = 8'h00; m_ack = 4'h0;
  endtask

  task automatic model_step();
    int acked;
    int c;
    acked = -1;
    m_ack = 4'h0;
    if (!m_active) begin
      if (cen) begin
        for (int k = 0; k < 4; k++) begin
`ifdef JT053260_ROMARB_FIXPRIO_EN
          c = k;
`else
          c = (m_last + 1 + k) % 4;
`endif
          if (!m_active && ch_req[c] && c != m_prev_ack) begin
            m_active = 1; m_win = c; m_age = 0; m_drop = 0; m_last = c;
            m_addr = ch_addr[c*AW +: AW];
          end
        end
      end
    end else begin
      m_age++;
      if (!ch_req[m_win]) m_drop = 1;
      if (m_age >= 2 && (rom_ok || (m_age - 1 == TOUT))) begin
        m_active = 0;
        if (!m_drop) begin
          m_ack[m_win] = 1'b1;
          acked = m_win;
          m_data = rom_ok ? rom_data : 8'h00;
        end
        if (!rom_ok) m_terr = 1;
      end
    end
    m_prev_ack = acked;
  endtask

  task automatic cmp_model();
    chk("model_cs", 32'(rom_cs), 32'(m_active));
    chk("model_busy", 32'(busy), 32'(m_active));
    chk("model_ack", 32'(ch_ack), 32'(m_ack));
    chk("model_data", 32'(ch_data), 32'(m_data));
    chk("model_terr", 32'(tout_err), 32'(m_terr));
    if (m_active) chk("model_addr", 32'(rom_addr), 32'(m_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cs", 32'(rom_cs), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_ack", 32'(ch_ack), 0);
    chk("rst_data", 32'(ch_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(tout_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int chan_of(input logic [AW-1:0] a);
    chan_of = -1;
    for (int c = 0; c < 4; c++) if (ch_addr[c*AW +: AW] == a) chan_of = c;
  endfunction

  task automatic rand_drive(input int cyc);
    int okp;
    okp = ((cyc / 400) % 2 == 1) ? 5 : 45;
    cen = ($urandom_range(0, 9) != 0);
    for (int c = 0; c < 4; c++) begin
      if (ch_req[c]) begin
        if (hold[c]) begin
          ch_req[c] = 1'b0; hold[c] = 0;
        end else if (ch_ack[c]) begin
          if ($urandom_range(0, 1) == 0) ch_req[c] = 1'b0;
          else hold[c] = 1;
        end else if ($urandom_range(0, 99) < 2) begin
          ch_req[c] = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 30) begin
        ch_req[c] = 1'b1;
        hold[c] = 0;
        ch_addr[c*AW +: AW] = AW'($urandom);
      end
      if ($urandom_range(0, 19) == 0) ch_addr[c*AW +: AW] = AW'($urandom);
    end
    rom_ok   = ($urandom_range(0, 99) < okp);
    rom_data = 8'($urandom);
  endtask

  typedef struct packed {
    logic          cen;
    logic [3:0]    req;
    logic          ok;
    logic [7:0]    rd;
    logic          e_cs;
    logic [3:0]    e_ack;
    logic [7:0]    e_data;
    logic          e_busy;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl [12];
  int   got [5];
  int   exp_order [5];
  int   ng;
  logic prev_cs;

  initial begin
    cen = 1'b1; ch_req = 4'h0; rom_ok = 1'b0; rom_data = 8'h00;
    ch_addr = {21'h1F00F, 21'h1ABCD, 21'h01111, 21'h00100};
    rst_n = 1'b0;
    do_reset();

    // Single fetch, stale rom_ok in ISSUE, drop-delay mask, cen gating.
    tbl[0]  = '{1'b1, 4'b0100, 1'b0, 8'h00, 1'b1, 4'b0000, 8'h00, 1'b1, 21'h1ABCD};
    tbl[1]  = '{1'b1, 4'b0100, 1'b1, 8'hFF, 1'b1, 4'b0000, 8'h00, 1'b1, 21'h1ABCD};
    tbl[2]  = '{1'b1, 4'b0100, 1'b1, 8'h5A, 1'b0, 4'b0100, 8'h5A, 1'b0, 21'h00000};
    tbl[3]  = '{1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h5A, 1'b0, 21'h00000};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h5A, 1'b0, 21'h00000};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h5A, 1'b0, 21'h00000};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h5A, 1'b0, 21'h00000};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 8'h00, 1'b1, 4'b0000, 8'h5A, 1'b1, 21'h00100};
    tbl[8]  = '{1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 4'b0000, 8'h5A, 1'b1, 21'h00100};
    tbl[9]  = '{1'b0, 4'b0001, 1'b1, 8'h11, 1'b0, 4'b0001, 8'h11, 1'b0, 21'h00000};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h11, 1'b0, 21'h00000};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h11, 1'b0, 21'h00000};
    for (int i = 0; i < 12; i++) begin
      cen = tbl[i].cen; ch_req = tbl[i].req; rom_ok = tbl[i].ok; rom_data = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_cs", i), 32'(rom_cs), 32'(tbl[i].e_cs));
      chk($sformatf("tbl%0d_ack", i), 32'(ch_ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_data", i), 32'(ch_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_cs) chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
    end

    // All four requests held: grant order.
`ifdef JT053260_ROMARB_FIXPRIO_EN
    exp_order = '{0, 1, 0, 1, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    cen = 1'b1; ch_req = 4'hF; rom_ok = 1'b1; rom_data = 8'h3C;
    got = '{-1, -1, -1, -1, -1};
    ng = 0; prev_cs = 1'b0;
    for (int t = 0; t < 60 && ng < 5; t++) begin
      tick();
      if (rom_cs && !prev_cs) begin
        got[ng] = chan_of(rom_addr);
        ng++;
      end
      prev_cs = rom_cs;
    end
    chk("rr_grant_count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), 32'(got[i]), 32'(exp_order[i]));

    // rom_ok stuck low: forced completion after TOUT WAIT cycles.
    do_reset();
    ch_req = 4'b1000; rom_ok = 1'b0;
    tick();
    chk("to_grant_cs", 32'(rom_cs), 1);
    for (int i = 0; i < TOUT; i++) begin
      tick();
      chk("to_wait_ack", 32'(ch_ack), 0);
    end
    tick();
    chk("to_ack", 32'(ch_ack), 32'(4'b1000));
    chk("to_data", 32'(ch_data), 0);
    chk("to_err", 32'(tout_err), 1);
    chk("to_cs", 32'(rom_cs), 0);
    ch_req = 4'h0;
    repeat (3) tick();
    chk("to_sticky", 32'(tout_err), 1);

    // rom_ok arriving on the timeout cycle wins.
    do_reset();
    ch_req = 4'b1000; rom_ok = 1'b0;
    tick();
    repeat (TOUT) tick();
    rom_ok = 1'b1; rom_data = 8'hA5;
    tick();
    chk("tie_ack", 32'(ch_ack), 32'(4'b1000));
    chk("tie_data", 32'(ch_data), 32'(8'hA5));
    chk("tie_err", 32'(tout_err), 0);

    // ch1 drops during WAIT: access completes silently, next grant normal.
    do_reset();
    ch_req = 4'b0010; rom_ok = 1'b0;
    tick(); tick();
    ch_req = 4'b0000;
    tick();
    chk("drop_cs_wait", 32'(rom_cs), 1);
    rom_ok = 1'b1; rom_data = 8'h77;
    tick();
    chk("drop_cs", 32'(rom_cs), 0);
    chk("drop_ack", 32'(ch_ack), 0);
    chk("drop_data", 32'(ch_data), 0);
    rom_ok = 1'b0; ch_req = 4'b0010;
    tick();
    chk("drop_regrant", 32'(rom_cs), 1);
    chk("drop_regrant_addr", 32'(rom_addr), 32'(21'h01111));
    tick();
    rom_ok = 1'b1; rom_data = 8'h42;
    tick();
    chk("drop_next_ack", 32'(ch_ack), 32'(4'b0010));
    chk("drop_next_data", 32'(ch_data), 32'(8'h42));

    // Reset in WAIT abandons the access; fresh arbitration starts at ch0.
    do_reset();
    ch_req = 4'b0100; rom_ok = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(busy), 1);
    ch_req = 4'hF;
    do_reset();
    tick();
    chk("mid_cs", 32'(rom_cs), 1);
    chk("mid_addr", 32'(rom_addr), 32'(21'h00100));
    chk("mid_ack", 32'(ch_ack), 0);

    // Random traffic against the model.
    do_reset();
    ch_req = 4'h0;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_drive(cyc);
      if ($urandom_range(0, 599) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
